// File: rtl/channel_change_responder.sv
`default_nettype none
// ============================================================================
// Module   : channel_change_responder
// Purpose  : Answers a ChannelChange request. It writes the CC2420 FSCTRL word
//            for the new channel over write-only SPI, strobes SRXON, then
//            pulses ChannelChange_done.
// Revision : 1.0 - initial release
// ============================================================================
module channel_change_responder #(
    parameter int         SCLK_DIV     = 4,
    parameter logic [7:0] FSCTRL_ADDR  = 8'h18,
    parameter logic [9:0] FREQ_BASE    = 10'd357,
    parameter logic [5:0] FSCTRL_UPPER = 6'b010000,
    parameter logic [7:0] STROBE_CMD   = 8'h03
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Channel,
    input  logic       ChannelChange,
    output logic       ChannelChange_done,
    output logic       SPI_SCLK,
    output logic       SPI_MOSI,
    output logic       SPI_CSn,
    output logic       Busy,
    output logic [2:0] State
);

    localparam int CNT_W = $clog2(2 * SCLK_DIV) + 1;

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_LOAD     = 3'd1;
    localparam logic [2:0] c_CS_SETUP = 3'd2;
    localparam logic [2:0] c_SHIFT    = 3'd3;
    localparam logic [2:0] c_CS_HOLD  = 3'd4;
    localparam logic [2:0] c_GAP      = 3'd5;
    localparam logic [2:0] c_DONE     = 3'd6;
    localparam logic [2:0] c_WAIT_LOW = 3'd7;

    localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(2 * SCLK_DIV - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_bitCnt;
    logic [23:0]      r_shift;
    logic [3:0]       r_chanQ;
    logic             r_strobe;
    logic [9:0]       w_freq;

    assign w_freq   = FREQ_BASE + ({6'd0, r_chanQ} * 10'd5);
    // MOSI is the MSB of the shift register; it is cleared whenever CSn rises.
    assign SPI_MOSI = r_shift[23];
    assign State    = r_state;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state            <= c_IDLE;
            r_cnt              <= '0;
            r_bitCnt           <= '0;
            r_shift            <= '0;
            r_chanQ            <= '0;
            r_strobe           <= 1'b0;
            ChannelChange_done <= 1'b0;
            SPI_SCLK           <= 1'b0;
            SPI_CSn            <= 1'b1;
            Busy               <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (ChannelChange) begin
                        r_chanQ <= Channel;
                        Busy    <= 1'b1;
                        r_state <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    r_shift  <= {FSCTRL_ADDR, FSCTRL_UPPER, w_freq};
                    r_bitCnt <= 5'd24;
                    r_strobe <= 1'b0;
                    r_cnt    <= '0;
                    SPI_CSn  <= 1'b0;
                    r_state  <= c_CS_SETUP;
                end
                c_CS_SETUP: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                c_SHIFT: begin
                    if (r_cnt != c_HALF_LAST) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_cnt <= '0;
                        if (!SPI_SCLK) begin
                            SPI_SCLK <= 1'b1;
                        end else begin
                            SPI_SCLK <= 1'b0;
                            // Last bit stays on MOSI through CS_HOLD.
                            if (r_bitCnt == 5'd1) begin
                                r_state <= c_CS_HOLD;
                            end else begin
                                r_shift  <= {r_shift[22:0], 1'b0};
                                r_bitCnt <= r_bitCnt - 5'd1;
                            end
                        end
                    end
                end
                c_CS_HOLD: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= '0;
                        SPI_CSn <= 1'b1;
                        if (r_strobe) begin
                            ChannelChange_done <= 1'b1;
                            r_state            <= c_DONE;
                        end else begin
                            r_state <= c_GAP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                c_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_cnt    <= '0;
                        r_shift  <= {STROBE_CMD, 16'h0000};
                        r_bitCnt <= 5'd8;
                        r_strobe <= 1'b1;
                        SPI_CSn  <= 1'b0;
                        r_state  <= c_CS_SETUP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                c_DONE: begin
                    ChannelChange_done <= 1'b0;
                    r_state            <= c_WAIT_LOW;
                end
                c_WAIT_LOW: begin
                    if (!ChannelChange) begin
                        Busy    <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_channel_change_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_channel_change_responder
// Purpose  : Directed self-checking bench for channel_change_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_channel_change_responder;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] Channel = 4'd0;
    logic       ChannelChange = 1'b0;
    logic       ChannelChange_done;
    logic       SPI_SCLK;
    logic       SPI_MOSI;
    logic       SPI_CSn;
    logic       Busy;
    logic [2:0] State;

    channel_change_responder dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .Channel            (Channel),
        .ChannelChange      (ChannelChange),
        .ChannelChange_done (ChannelChange_done),
        .SPI_SCLK           (SPI_SCLK),
        .SPI_MOSI           (SPI_MOSI),
        .SPI_CSn            (SPI_CSn),
        .Busy               (Busy),
        .State              (State)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    logic [31:0] monWord = '0;
    int          monBits = 0;
    logic [31:0] txWord [32];
    int          txBits [32];
    int          txCount = 0;
    int          strayEdges = 0;
    int          doneCount = 0;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SPI slave model: mode 0, sample on SCLK rise, frame closes on CSn rise.
    always @(posedge SPI_SCLK) begin
        if (SPI_CSn) begin
            strayEdges++;
        end else begin
            monWord = {monWord[30:0], SPI_MOSI};
            monBits++;
        end
    end

    always @(posedge SPI_CSn) begin
        if (txCount < 32) begin
            txWord[txCount] = monWord;
            txBits[txCount] = monBits;
        end
        txCount++;
        monWord = '0;
        monBits = 0;
    end

    always @(posedge Clock) begin
        if (ChannelChange_done === 1'b1) doneCount++;
    end

    task automatic runXfer(input string tag, input logic [3:0] chan, input int changeAt,
                           input logic [3:0] chan2, input int dropAt, input int holdExtra,
                           input logic [23:0] expWord);
        int txBase;
        int doneBase;
        int strayBase;
        int n;
        bit seen;
        txBase    = txCount;
        doneBase  = doneCount;
        strayBase = strayEdges;
        n         = 0;
        seen      = 1'b0;
        @(negedge Clock);
        Channel       = chan;
        ChannelChange = 1'b1;
        @(posedge Clock);
        #1;
        checkEq({tag, "_accept_state"}, 32'(State), 32'd1);
        while (n < 400 && !seen) begin
            @(negedge Clock);
            if (n == changeAt) Channel = chan2;
            if (n == dropAt) ChannelChange = 1'b0;
            @(posedge Clock);
            n++;
            #1;
            if (ChannelChange_done === 1'b1) seen = 1'b1;
        end
        checkEq({tag, "_done_latency"}, 32'(n), 32'd281);
        checkEq({tag, "_tx_count"}, 32'(txCount - txBase), 32'd2);
        checkEq({tag, "_write_word"}, txWord[txBase], {8'h00, expWord});
        checkEq({tag, "_write_bits"}, 32'(txBits[txBase]), 32'd24);
        checkEq({tag, "_strobe_word"}, txWord[txBase + 1], 32'h0000_0003);
        checkEq({tag, "_strobe_bits"}, 32'(txBits[txBase + 1]), 32'd8);
        checkEq({tag, "_csn_at_done"}, 32'(SPI_CSn), 32'd1);
        @(posedge Clock);
        #1;
        checkEq({tag, "_done_width"}, 32'(ChannelChange_done), 32'd0);
        checkEq({tag, "_wait_low"}, 32'(State), 32'd7);
        repeat (holdExtra) @(posedge Clock);
        #1;
        checkEq({tag, "_still_wait_low"}, 32'(State), 32'd7);
        checkEq({tag, "_no_retrigger"}, 32'(txCount - txBase), 32'd2);
        @(negedge Clock);
        ChannelChange = 1'b0;
        @(posedge Clock);
        #1;
        checkEq({tag, "_idle_state"}, 32'(State), 32'd0);
        checkEq({tag, "_idle_busy"}, 32'(Busy), 32'd0);
        checkEq({tag, "_idle_csn"}, 32'(SPI_CSn), 32'd1);
        checkEq({tag, "_done_count"}, 32'(doneCount - doneBase), 32'd1);
        checkEq({tag, "_stray_sclk"}, 32'(strayEdges - strayBase), 32'd0);
    endtask

    initial begin
        int doneBase;
        repeat (3) @(posedge Clock);
        #1;
        checkEq("rst_csn", 32'(SPI_CSn), 32'd1);
        checkEq("rst_sclk", 32'(SPI_SCLK), 32'd0);
        checkEq("rst_mosi", 32'(SPI_MOSI), 32'd0);
        checkEq("rst_done", 32'(ChannelChange_done), 32'd0);
        checkEq("rst_busy", 32'(Busy), 32'd0);
        checkEq("rst_state", 32'(State), 32'd0);
        @(negedge Clock);
        Reset = 1'b0;

        // Abort a transfer with a 3-cycle reset in the middle of SHIFT.
        Channel       = 4'd7;
        ChannelChange = 1'b1;
        repeat (60) @(posedge Clock);
        #1;
        checkEq("abort_in_shift", 32'(State), 32'd3);
        @(negedge Clock);
        Reset         = 1'b1;
        ChannelChange = 1'b0;
        doneBase      = doneCount;
        @(posedge Clock);
        #1;
        checkEq("abort_csn", 32'(SPI_CSn), 32'd1);
        checkEq("abort_sclk", 32'(SPI_SCLK), 32'd0);
        checkEq("abort_done", 32'(ChannelChange_done), 32'd0);
        checkEq("abort_state", 32'(State), 32'd0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        repeat (300) @(posedge Clock);
        #1;
        checkEq("abort_no_done", 32'(doneCount - doneBase), 32'd0);
        checkEq("abort_idle", 32'(State), 32'd0);

        runXfer("ch0",    4'd0,  -1, 4'd0, -1,  0, 24'h184165);
        runXfer("ch15",   4'd15, -1, 4'd0, -1,  0, 24'h1841B0);
        runXfer("ch5",    4'd5,  -1, 4'd0, -1,  0, 24'h18417E);
        runXfer("chg3to9", 4'd3, 50, 4'd9, -1,  0, 24'h184174);
        runXfer("hold10", 4'd1,  -1, 4'd0, -1, 10, 24'h18416A);
        runXfer("drop",   4'd10, -1, 4'd0, 100, 0, 24'h184197);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
